// File: rtl/memory_access_unit.sv
// Memory stage of the RV32 pipeline: issues one data-memory access at a time over a
// valid/ready handshake, stalls upstream while it is outstanding, and registers MEM/WB.
//
// state     | meaning
// IDLE      | pass non-memory results to writeback; decode and check new accesses
// REQUEST   | request held on mem_req_*, waiting for mem_req_ready
// WAIT_RESP | load accepted, waiting for mem_resp_valid
module memory_access_unit #(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    memRead,
    input  logic                    memWrite,
    input  logic                    regWrite,
    input  logic [4:0]              rd,
    input  logic [2:0]              funct3,
    input  logic [DATA_WIDTH-1:0]   ALU_result,
    input  logic [31:0]             rs2_data,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_write,
    output logic [ADDRESS_BITS-1:0] mem_req_address,
    output logic [31:0]             mem_req_wdata,
    output logic [3:0]              mem_req_byte_en,
    input  logic                    mem_resp_valid,
    input  logic [31:0]             mem_resp_rdata,
    output logic                    stall,
    output logic                    misaligned,
    output logic                    wb_regWrite,
    output logic [4:0]              wb_rd,
    output logic [DATA_WIDTH-1:0]   wb_data
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQUEST   = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    state_t state, state_next;

    // CORE only tags the instance; it has no functional effect.
    if (CORE < 0) begin : g_invalid_core
    end

    logic        mem_op;
    logic        is_store;
    logic        aligned;
    logic [3:0]  store_byte_en;
    logic [31:0] store_wdata;
    logic [31:0] load_result;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    logic        regwrite_q;
    logic [4:0]  rd_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;

    always_comb begin
        mem_op   = memRead | memWrite;
        is_store = memWrite & ~memRead;
        aligned  = 1'b1;
        case (funct3)
            3'b001, 3'b101: aligned = ~ALU_result[0];
            3'b010:         aligned = (ALU_result[1:0] == 2'b00);
            default:        aligned = 1'b1;
        endcase
    end

    always_comb begin
        store_byte_en = 4'b1111;
        store_wdata   = rs2_data;
        if (is_store) begin
            case (funct3)
                3'b000: begin
                    store_byte_en = 4'b0001 << ALU_result[1:0];
                    store_wdata   = {4{rs2_data[7:0]}};
                end
                3'b001: begin
                    store_byte_en = 4'b0011 << ALU_result[1:0];
                    store_wdata   = {2{rs2_data[15:0]}};
                end
                default: begin
                    store_byte_en = 4'b1111;
                    store_wdata   = rs2_data;
                end
            endcase
        end
    end

    always_comb begin
        load_byte   = mem_resp_rdata[{offset_q, 3'b000} +: 8];
        load_half   = offset_q[1] ? mem_resp_rdata[31:16] : mem_resp_rdata[15:0];
        load_result = mem_resp_rdata;
        case (funct3_q)
            3'b000:  load_result = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_result = {24'd0, load_byte};
            3'b001:  load_result = {{16{load_half[15]}}, load_half};
            3'b101:  load_result = {16'd0, load_half};
            default: load_result = mem_resp_rdata;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        misaligned = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op && !reset) begin
                    if (aligned) begin
                        stall      = 1'b1;
                        state_next = REQUEST;
                    end else begin
                        misaligned = 1'b1;
                    end
                end
            end
            REQUEST: begin
                stall = ~(mem_req_ready & mem_req_write);
                if (mem_req_ready) begin
                    state_next = mem_req_write ? IDLE : WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                stall = ~mem_resp_valid;
                if (mem_resp_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_req_valid   <= 1'b0;
            mem_req_write   <= 1'b0;
            mem_req_address <= '0;
            mem_req_wdata   <= '0;
            mem_req_byte_en <= '0;
            wb_regWrite     <= 1'b0;
            wb_rd           <= '0;
            wb_data         <= '0;
            regwrite_q      <= 1'b0;
            rd_q            <= '0;
            funct3_q        <= '0;
            offset_q        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!mem_op) begin
                        wb_regWrite <= regWrite;
                        wb_rd       <= rd;
                        wb_data     <= ALU_result;
                    end else begin
                        wb_regWrite <= 1'b0;
                        if (aligned) begin
                            mem_req_valid   <= 1'b1;
                            mem_req_write   <= is_store;
                            mem_req_address <= {ALU_result[ADDRESS_BITS-1:2], 2'b00};
                            mem_req_wdata   <= store_wdata;
                            mem_req_byte_en <= store_byte_en;
                            regwrite_q      <= regWrite;
                            rd_q            <= rd;
                            funct3_q        <= funct3;
                            offset_q        <= ALU_result[1:0];
                        end
                    end
                end
                REQUEST: begin
                    wb_regWrite <= 1'b0;
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                    end
                end
                WAIT_RESP: begin
                    if (mem_resp_valid) begin
                        wb_regWrite <= regwrite_q;
                        wb_rd       <= rd_q;
                        wb_data     <= DATA_WIDTH'(load_result);
                    end else begin
                        wb_regWrite <= 1'b0;
                    end
                end
                default: wb_regWrite <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: ALU passthrough, loads, stores with wait states,
// misalignment, reset mid-access and back-to-back load/ALU writeback.
module tb_memory_access_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        memRead, memWrite, regWrite;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [31:0] ALU_result;
    logic [31:0] rs2_data;
    logic        mem_req_valid, mem_req_ready, mem_req_write;
    logic [19:0] mem_req_address;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_byte_en;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        stall, misaligned, wb_regWrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int errors = 0;
    int checks = 0;

    memory_access_unit #(.CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20)) dut (
        .clock(clock), .reset(reset),
        .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite),
        .rd(rd), .funct3(funct3), .ALU_result(ALU_result), .rs2_data(rs2_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write), .mem_req_address(mem_req_address),
        .mem_req_wdata(mem_req_wdata), .mem_req_byte_en(mem_req_byte_en),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .stall(stall), .misaligned(misaligned),
        .wb_regWrite(wb_regWrite), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    always #5 clock = ~clock;

    task automatic drive_idle();
        memRead = 0; memWrite = 0; regWrite = 0; rd = 0;
        funct3 = 0; ALU_result = 0; rs2_data = 0;
    endtask

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset = 1; drive_idle();
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0;
        step(); step();
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", mem_req_valid); end
        checks++; if (mem_req_write !== 1'b0 || mem_req_address !== 20'd0 || mem_req_wdata !== 32'd0 || mem_req_byte_en !== 4'd0) begin
            errors++; $display("FAIL reset_req_fields: write=%b addr=%h wdata=%h be=%b want all 0", mem_req_write, mem_req_address, mem_req_wdata, mem_req_byte_en); end
        checks++; if (wb_regWrite !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0) begin
            errors++; $display("FAIL reset_wb: regWrite=%b rd=%0d data=%h want 0/0/0", wb_regWrite, wb_rd, wb_data); end
        checks++; if (misaligned !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL reset_flags: misaligned=%b stall=%b want 0/0", misaligned, stall); end
        reset = 0;
    endtask

    task automatic test_alu();
        regWrite = 1; rd = 5; ALU_result = 32'h1234;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b want 0", stall); end
        step();
        checks++; if (wb_rd !== 5'd5 || wb_data !== 32'h1234 || wb_regWrite !== 1'b1) begin
            errors++; $display("FAIL alu_wb: rd=%0d data=%h regWrite=%b want 5/00001234/1", wb_rd, wb_data, wb_regWrite); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall_after: got %b want 0", stall); end
        drive_idle();
    endtask

    task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] rdata, input logic [31:0] expected, input int resp_delay);
        int stall_cycles;
        logic [19:0] exp_addr;
        stall_cycles = 0;
        exp_addr = {addr[19:2], 2'b00};
        memRead = 1; memWrite = 0; regWrite = 1; rd = 9; funct3 = f3; ALU_result = addr;
        rs2_data = 32'hFFFF_FFFF; mem_req_ready = 1; mem_resp_valid = 0;
        #1;
        if (stall) stall_cycles++;
        step();
        checks++; if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b0 || mem_req_address !== exp_addr || mem_req_byte_en !== 4'b1111) begin
            errors++; $display("FAIL %s_req: valid=%b write=%b addr=%h be=%b want 1/0/%h/1111", name, mem_req_valid, mem_req_write, mem_req_address, mem_req_byte_en, exp_addr); end
        if (stall) stall_cycles++;
        step();
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL %s_req_drop: valid=%b want 0", name, mem_req_valid); end
        for (int i = 0; i < resp_delay; i++) begin
            if (stall) stall_cycles++;
            step();
        end
        mem_resp_valid = 1; mem_resp_rdata = rdata;
        drive_idle();
        #1;
        if (stall) stall_cycles++;
        step();
        mem_resp_valid = 0;
        checks++; if (wb_data !== expected || wb_rd !== 5'd9 || wb_regWrite !== 1'b1) begin
            errors++; $display("FAIL %s_wb: data=%h rd=%0d regWrite=%b want %h/9/1", name, wb_data, wb_rd, wb_regWrite, expected); end
        checks++; if (stall_cycles !== 2 + resp_delay) begin
            errors++; $display("FAIL %s_stall_cycles: got %0d want %0d", name, stall_cycles, 2 + resp_delay); end
    endtask

    task automatic test_store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata, input int ready_delay);
        int stall_cycles;
        int held_bad;
        logic [19:0] exp_addr;
        stall_cycles = 0;
        held_bad = 0;
        exp_addr = {addr[19:2], 2'b00};
        memWrite = 1; memRead = 0; regWrite = 1; rd = 3; funct3 = f3; ALU_result = addr;
        rs2_data = data; mem_req_ready = 0; mem_resp_valid = 0;
        #1;
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL %s_misaligned: got %b want 0", name, misaligned); end
        if (stall) stall_cycles++;
        step();
        for (int i = 0; i < ready_delay; i++) begin
            if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b1 || mem_req_address !== exp_addr ||
                mem_req_byte_en !== exp_be || mem_req_wdata !== exp_wdata) held_bad++;
            if (stall) stall_cycles++;
            step();
        end
        checks++; if (held_bad !== 0) begin errors++; $display("FAIL %s_hold: unstable request in %0d wait cycles want 0", name, held_bad); end
        mem_req_ready = 1;
        drive_idle();
        #1;
        checks++; if (mem_req_valid !== 1'b1 || mem_req_write !== 1'b1 || mem_req_address !== exp_addr ||
                      mem_req_byte_en !== exp_be || mem_req_wdata !== exp_wdata) begin
            errors++; $display("FAIL %s_req: valid=%b write=%b addr=%h be=%b wdata=%h want 1/1/%h/%b/%h", name,
                mem_req_valid, mem_req_write, mem_req_address, mem_req_byte_en, mem_req_wdata, exp_addr, exp_be, exp_wdata); end
        if (stall) stall_cycles++;
        step();
        mem_req_ready = 0;
        checks++; if (mem_req_valid !== 1'b0 || wb_regWrite !== 1'b0) begin
            errors++; $display("FAIL %s_done: valid=%b wb_regWrite=%b want 0/0", name, mem_req_valid, wb_regWrite); end
        checks++; if (stall_cycles !== 1 + ready_delay) begin
            errors++; $display("FAIL %s_stall_cycles: got %0d want %0d", name, stall_cycles, 1 + ready_delay); end
    endtask

    task automatic test_misaligned(input string name, input logic rd_op, input logic [2:0] f3, input logic [31:0] addr);
        regWrite = 1; rd = 4; ALU_result = 32'h77;
        step();
        memRead = rd_op; memWrite = ~rd_op; regWrite = 1; rd = 6; funct3 = f3; ALU_result = addr;
        #1;
        checks++; if (misaligned !== 1'b1 || stall !== 1'b0) begin
            errors++; $display("FAIL %s_pulse: misaligned=%b stall=%b want 1/0", name, misaligned, stall); end
        step();
        drive_idle();
        #1;
        checks++; if (mem_req_valid !== 1'b0 || wb_regWrite !== 1'b0 || misaligned !== 1'b0) begin
            errors++; $display("FAIL %s_after: req_valid=%b wb_regWrite=%b misaligned=%b want 0/0/0", name, mem_req_valid, wb_regWrite, misaligned); end
        step();
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL %s_no_req: req_valid=%b want 0", name, mem_req_valid); end
    endtask

    task automatic test_reset_mid();
        memRead = 1; memWrite = 0; regWrite = 1; rd = 12; funct3 = 3'b010; ALU_result = 32'h300;
        mem_req_ready = 1; mem_resp_valid = 0;
        step();
        step();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rmid_wait_stall: got %b want 1", stall); end
        reset = 1;
        step();
        reset = 0; mem_req_ready = 0;
        drive_idle();
        #1;
        checks++; if (mem_req_valid !== 1'b0 || wb_regWrite !== 1'b0) begin
            errors++; $display("FAIL rmid_after_reset: req_valid=%b wb_regWrite=%b want 0/0", mem_req_valid, wb_regWrite); end
        mem_resp_valid = 1; mem_resp_rdata = 32'hCAFE_F00D;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rmid_late_resp_stall: got %b want 0", stall); end
        step();
        mem_resp_valid = 0;
        checks++; if (wb_regWrite !== 1'b0 || wb_data !== 32'd0) begin
            errors++; $display("FAIL rmid_no_wb: regWrite=%b data=%h want 0/00000000", wb_regWrite, wb_data); end
        regWrite = 1; rd = 2; ALU_result = 32'h99;
        step();
        checks++; if (wb_regWrite !== 1'b1 || wb_rd !== 5'd2 || wb_data !== 32'h99) begin
            errors++; $display("FAIL rmid_idle_alu: regWrite=%b rd=%0d data=%h want 1/2/00000099", wb_regWrite, wb_rd, wb_data); end
        drive_idle();
    endtask

    task automatic test_back_to_back();
        memRead = 1; memWrite = 0; regWrite = 1; rd = 7; funct3 = 3'b010; ALU_result = 32'h200;
        mem_req_ready = 1; mem_resp_valid = 0;
        step();
        step();
        mem_resp_valid = 1; mem_resp_rdata = 32'hDEAD_BEEF;
        memRead = 0; regWrite = 1; rd = 8; funct3 = 3'b000; ALU_result = 32'h55;
        step();
        mem_resp_valid = 0; mem_req_ready = 0;
        checks++; if (wb_regWrite !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL b2b_lw_wb: regWrite=%b rd=%0d data=%h want 1/7/deadbeef", wb_regWrite, wb_rd, wb_data); end
        step();
        checks++; if (wb_regWrite !== 1'b1 || wb_rd !== 5'd8 || wb_data !== 32'h55) begin
            errors++; $display("FAIL b2b_add_wb: regWrite=%b rd=%0d data=%h want 1/8/00000055", wb_regWrite, wb_rd, wb_data); end
        drive_idle();
        step();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load("lb",  3'b000, 32'h103, 32'h80FF_0000, 32'hFFFF_FF80, 0);
        test_load("lbu", 3'b100, 32'h103, 32'h80FF_0000, 32'h0000_0080, 0);
        test_load("lh",  3'b001, 32'h102, 32'h80FF_0000, 32'hFFFF_80FF, 2);
        test_load("lhu", 3'b101, 32'h100, 32'h1234_8001, 32'h0000_8001, 0);
        test_load("lw",  3'b010, 32'h204, 32'h89AB_CDEF, 32'h89AB_CDEF, 1);
        test_store("sh", 3'b001, 32'h102, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD, 3);
        test_store("sb", 3'b000, 32'h101, 32'h0000_005A, 4'b0010, 32'h5A5A_5A5A, 0);
        test_store("sw", 3'b010, 32'h104, 32'h1122_3344, 4'b1111, 32'h1122_3344, 0);
        test_misaligned("lw_mis", 1'b1, 3'b010, 32'h101);
        test_misaligned("sh_mis", 1'b0, 3'b001, 32'h103);
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_access_unit.md
# memory_access_unit

Memory stage of the pipelined RV32 core. It sits directly downstream of the EX/MEM pipeline register and consumes that register's outputs (ALU result, rs2 data, memRead/memWrite, regWrite, rd), plus funct3. It performs the data-memory access through a valid/ready request and response handshake, and extracts or sign-extends load data. It stalls the upstream stages while an access is outstanding and drives the registered MEM/WB values consumed by writeback.

## Interface
Parameters:
- CORE, 0, core index carried for multi-core instantiation; no functional effect.
- DATA_WIDTH, 32, width of ALU_result and wb_data.
- ADDRESS_BITS, 20, byte-address width presented to data memory.

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- memRead  in  1  load in the EX/MEM register.
- memWrite  in  1  store in the EX/MEM register.
- regWrite  in  1  instruction writes rd.
- rd  in  5  destination register.
- funct3  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ALU_result  in  DATA_WIDTH  effective byte address, or result for non-memory instructions.
- rs2_data  in  32  store data.
- mem_req_valid  out  1  request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_write  out  1  1 = store, 0 = load.
- mem_req_address  out  ADDRESS_BITS  word-aligned byte address (bits [1:0] = 0).
- mem_req_wdata  out  32  lane-replicated store data.
- mem_req_byte_en  out  4  byte enables.
- mem_resp_valid  in  1  load data valid.
- mem_resp_rdata  in  32  aligned load word.
- stall  out  1  upstream must hold the EX/MEM register.
- misaligned  out  1  one-cycle pulse for a misaligned access.
- wb_regWrite  out  1  writeback enable.
- wb_rd  out  5  writeback register.
- wb_data  out  DATA_WIDTH  writeback value.

## Operation
The unit is a three-state FSM: IDLE, REQUEST, WAIT_RESP.

IDLE, no memory operation:
- wb_regWrite, wb_rd and wb_data <= regWrite, rd, ALU_result every edge.
- stall = 0.

IDLE, memRead or memWrite:
- Alignment check: W requires addr[1:0] = 0; H/HU requires addr[0] = 0.
- If both memRead and memWrite are asserted, the access is treated as a load.
- Misaligned access:
  - No request is issued.
  - misaligned = 1 for that cycle; wb_regWrite <= 0; stall = 0.
- Aligned access:
  - stall = 1 (combinational).
  - Latch address, write flag, byte enables, wdata, rd, regWrite, funct3 and addr[1:0].
  - wb_regWrite <= 0 (bubble); go to REQUEST.

Store encoding:
- SB: byte_en = 0001 << addr[1:0]; wdata = {4{rs2[7:0]}}.
- SH: byte_en = 0011 << addr[1:0]; wdata = {2{rs2[15:0]}}.
- SW: byte_en = 1111; wdata = rs2.
- Loads drive byte_en = 1111.

REQUEST:
- mem_req_valid = 1; all mem_req_* outputs are registered and stable until accepted.
- stall = 1, except in the cycle the request is accepted for a store.
- On mem_req_ready: store → IDLE with wb_regWrite <= 0; load → WAIT_RESP.
- mem_resp_valid is ignored in this state.

WAIT_RESP:
- stall = 1 until mem_resp_valid.
- On mem_resp_valid:
  - Select the byte/half lane by the latched addr[1:0].
  - B/H sign-extend; BU/HU zero-extend; W (and any undefined funct3) takes the full word.
  - wb_data <= result; wb_regWrite <= latched regWrite; wb_rd <= latched rd.
  - stall = 0; go to IDLE.

Upstream register behaviour:
- stall is low in every completion cycle, so the upstream register loads the next instruction on the same edge the FSM returns to IDLE.

## Timing
- Reset: state IDLE; mem_req_valid, mem_req_write, mem_req_address, mem_req_wdata, mem_req_byte_en, misaligned, wb_regWrite, wb_rd and wb_data all 0.
- Reset mid-transaction abandons the access. mem_req_valid is 0 from the cycle after the reset edge, and a late mem_resp_valid is ignored.
- Non-memory instruction: wb_* updates on the first edge (latency 1).
- Load, zero wait states: IDLE → REQUEST → WAIT_RESP with response. wb_* is valid after the 3rd edge; stall is high for 2 cycles.
- Store, zero wait states: IDLE → REQUEST with ready. Complete after 2 edges; stall is high for 1 cycle.
- Each cycle of mem_req_ready = 0 in REQUEST, or mem_resp_valid = 0 in WAIT_RESP, adds one cycle.
- Exactly one request is outstanding at a time.

## Test plan
- ALU op (regWrite = 1, rd = 5, ALU_result = 0x1234): wb_rd = 5 and wb_data = 0x1234 after 1 edge; stall never asserts.
- LB at addr 0x103, zero wait states, rdata = 0x80FF0000: wb_data = 0xFFFFFF80 on the 3rd edge. LBU at the same address gives 0x00000080.
- SH at addr 0x102, rs2 = 0xABCD, mem_req_ready delayed 3 cycles: byte_en = 1100 and wdata = 0xABCDABCD held stable through the wait; stall high for 4 cycles; wb_regWrite = 0.
- LW at addr 0x101: misaligned pulses 1 cycle; mem_req_valid stays 0; wb_regWrite = 0; stall = 0.
- Reset asserted in WAIT_RESP, then mem_resp_valid: state IDLE, wb_regWrite stays 0, no writeback.
- Back-to-back LW (0x200) then ADD: the ADD result reaches wb_* exactly one edge after the LW writeback.
